// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the Alu instruction sequencer: instruction word
// width, Alu opcode values, the opcode screening function used before a word
// is issued, and the sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

  localparam int INST_WIDTH = 12;

  // Alu opcodes, {opcode[11:8], imm[7:0]}
  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_LDI = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_IOR = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_NOT = 4'h7;
  localparam logic [3:0] ALU_SHL = 4'h8;
  localparam logic [3:0] ALU_SHR = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_e;

  // True for every opcode the Alu implements; anything else must not be issued.
  function automatic logic alu_op_valid(input logic [3:0] op);
    logic valid_s;
    case (op)
      ALU_NOP, ALU_LDI, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_IOR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR: valid_s = 1'b1;
      default:                                     valid_s = 1'b0;
    endcase
    return valid_s;
  endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// ---------------------------------------------------------------------------
// alu_prog_mem
// Program buffer for the Alu sequencer: DEPTH words of INST_WIDTH bits,
// one synchronous write port and one asynchronous read port.
// Ports:
//   clock    in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   word to store
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational)
// ---------------------------------------------------------------------------
module alu_prog_mem
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INST_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [INST_WIDTH-1:0] rd_data
);

  logic [INST_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents need no reset because count gates validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Controller-side driver for the Alu instruction port. A host appends
// program words while idle; start issues them back-to-back on inst/inst_wen,
// screening each opcode first so an invalid word never reaches the Alu.
// After the last word the sequencer waits two cycles for the Alu register
// latency, then captures the Alu result.
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   prog_inst/_wen    append a program word (IDLE only)
//   start             run the program from entry 0 (IDLE/DONE)
//   pause             hold issue for one cycle (RUN)
//   clear             DONE -> IDLE, empty program
//   inst/inst_wen     registered instruction to the Alu
//   result            Alu result input
//   count/full        program occupancy
//   busy/done/error   status (error sticky until reset)
//   last_result       result captured on entry to DONE
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INST_WIDTH-1:0] prog_inst,
  input  logic                  prog_wen,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_wen,
  input  logic [7:0]            result,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            last_result
);

  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(1'b0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PC_ZERO   = (ADDR_WIDTH)'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = (ADDR_WIDTH)'(1'b1);

  seq_state_e            state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_next_s;
  logic [ADDR_WIDTH:0]   count_r, count_next_s;
  logic [INST_WIDTH-1:0] inst_r, inst_next_s;
  logic                  inst_wen_r, inst_wen_next_s;
  logic                  error_r, error_next_s;
  logic [7:0]            last_result_r, last_result_next_s;
  logic                  drain_r, drain_next_s;
  logic                  busy_r, busy_next_s;
  logic                  done_r, done_next_s;
  logic                  full_r, full_next_s;
  logic                  mem_we_s;
  logic                  is_full_s;
  logic                  last_word_s;
  logic [INST_WIDTH-1:0] rd_data_s;

  alu_prog_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prog_mem (
    .clock   (clock),
    .wr_en   (mem_we_s),
    .wr_addr (count_r[ADDR_WIDTH-1:0]),
    .wr_data (prog_inst),
    .rd_addr (pc_r),
    .rd_data (rd_data_s)
  );

  assign is_full_s   = (count_r == CNT_DEPTH);
  // pc is zero-extended so the comparison covers a full DEPTH-entry program.
  assign last_word_s = ({1'b0, pc_r} == (count_r - CNT_ONE));

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    state_next_s       = state_r;
    pc_next_s          = pc_r;
    count_next_s       = count_r;
    inst_next_s        = inst_r;
    inst_wen_next_s    = 1'b0;
    error_next_s       = error_r;
    last_result_next_s = last_result_r;
    drain_next_s       = drain_r;
    mem_we_s           = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (prog_wen && !is_full_s) begin
          mem_we_s     = 1'b1;
          count_next_s = count_r + CNT_ONE;
        end else begin
          mem_we_s     = 1'b0;
        end
        if (start && (count_r != CNT_ZERO)) begin
          pc_next_s    = PC_ZERO;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (pause) begin
          inst_wen_next_s = 1'b0;
        end else if (alu_op_valid(rd_data_s[11:8])) begin
          inst_next_s     = rd_data_s;
          inst_wen_next_s = 1'b1;
          pc_next_s       = pc_r + PC_ONE;
          if (last_word_s) begin
            state_next_s = ST_DRAIN;
            drain_next_s = 1'b0;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          inst_wen_next_s = 1'b0;
          error_next_s    = 1'b1;
          state_next_s    = ST_ERROR;
        end
      end

      // Two idle cycles let the final word's effect appear on result.
      ST_DRAIN: begin
        if (drain_r) begin
          last_result_next_s = result;
          drain_next_s       = 1'b0;
          state_next_s       = ST_DONE;
        end else begin
          drain_next_s       = 1'b1;
        end
      end

      ST_DONE: begin
        if (start) begin
          pc_next_s    = PC_ZERO;
          state_next_s = ST_RUN;
        end else if (clear) begin
          pc_next_s    = PC_ZERO;
          count_next_s = CNT_ZERO;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end

      ST_ERROR: begin
        error_next_s = 1'b1;
        state_next_s = ST_ERROR;
      end

      // An unreachable encoding is treated like an invalid opcode.
      default: begin
        error_next_s = 1'b1;
        state_next_s = ST_ERROR;
      end
    endcase

    busy_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
    done_next_s = (state_next_s == ST_DONE);
    full_next_s = (count_next_s == CNT_DEPTH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= PC_ZERO;
      count_r       <= CNT_ZERO;
      inst_r        <= {ALU_NOP, 8'h00};
      inst_wen_r    <= 1'b0;
      error_r       <= 1'b0;
      last_result_r <= 8'h00;
      drain_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      full_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      count_r       <= count_next_s;
      inst_r        <= inst_next_s;
      inst_wen_r    <= inst_wen_next_s;
      error_r       <= error_next_s;
      last_result_r <= last_result_next_s;
      drain_r       <= drain_next_s;
      busy_r        <= busy_next_s;
      done_r        <= done_next_s;
      full_r        <= full_next_s;
    end
  end

  assign inst        = inst_r;
  assign inst_wen    = inst_wen_r;
  assign count       = count_r;
  assign full        = full_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign last_result = last_result_r;

endmodule
